// File: rtl/knn_result_display.sv
// rtl/knn_result_display.sv - KNN result capture, page mux and busy blink for the 8 board LEDs
// Optional build macro: KNN_RESULT_HISTORY_EN (adds a 4-deep class history shown on the run page)
module knn_result_display #(
  parameter int BLINK_DIV = 25000000,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic        running,
  input  logic [1:0]  predicted_class,
  input  logic        K_mode,
  input  logic [15:0] latency,
  input  logic        btn_page,
  output logic [7:0]  leds,
  output logic        result_valid
);

  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    P_RESULT = 2'd0,
    P_LAT_LO = 2'd1,
    P_LAT_HI = 2'd2,
    P_RUNS   = 2'd3
  } page_t;

  page_t            page;
  page_t            page_nxt;
  logic             done_q;
  logic             capture_evt;
  logic [1:0]       cap_class;
  logic             cap_k;
  logic [15:0]      cap_lat;
  logic [CNT_W-1:0] run_cnt;
  logic [7:0]       run_cnt8;
  logic [BW-1:0]    blink_cnt;
  logic             blink;
  logic [7:0]       leds_nxt;
`ifdef KNN_RESULT_HISTORY_EN
  logic [7:0]       hist;
`endif

  // A capture happens only on the rising edge of done, however long done stays high
  assign capture_evt = done & ~done_q;

  // Run counter shown on 8 LEDs: zero-extend narrow counters, keep low byte of wide ones
  generate
    if (CNT_W >= 8) begin : g_cnt_wide
      assign run_cnt8 = run_cnt[7:0];
    end else begin : g_cnt_narrow
      assign run_cnt8 = {{(8 - CNT_W){1'b0}}, run_cnt};
    end
  endgenerate

  // Edge-detect register and captured result registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q       <= 1'b0;
      cap_class    <= 2'd0;
      cap_k        <= 1'b0;
      cap_lat      <= 16'd0;
      run_cnt      <= '0;
      result_valid <= 1'b0;
    end else begin
      done_q <= done;
      if (capture_evt) begin
        cap_class    <= predicted_class;
        cap_k        <= K_mode;
        cap_lat      <= latency;
        run_cnt      <= run_cnt + CNT_W'(1);
        result_valid <= 1'b1;
      end
    end
  end

`ifdef KNN_RESULT_HISTORY_EN
  // Class history: newest class shifts in at the bottom
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist <= 8'd0;
    end else if (capture_evt) begin
      hist <= {hist[5:0], predicted_class};
    end
  end
`endif

  // Page state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      page <= P_RESULT;
    end else begin
      page <= page_nxt;
    end
  end

  // Page next-state: a new capture always returns to the result page and swallows a coincident button pulse
  always_comb begin
    page_nxt = page;
    if (capture_evt) begin
      page_nxt = P_RESULT;
    end else if (btn_page) begin
      case (page)
        P_RESULT: page_nxt = P_LAT_LO;
        P_LAT_LO: page_nxt = P_LAT_HI;
        P_LAT_HI: page_nxt = P_RUNS;
        default:  page_nxt = P_RESULT;
      endcase
    end
  end

  // Busy blink: toggle every BLINK_DIV cycles while running, parked at zero when idle
  always_ff @(posedge clk) begin
    if (!reset || !running) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink     <= ~blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // LED content for the current page; blink is gated by running so the LED goes dark as soon as work stops
  always_comb begin
    leds_nxt = 8'd0;
    case (page)
      P_RESULT: leds_nxt = {blink & running, run_cnt8[2:0], result_valid, cap_k, cap_class};
      P_LAT_LO: leds_nxt = cap_lat[7:0];
      P_LAT_HI: leds_nxt = cap_lat[15:8];
`ifdef KNN_RESULT_HISTORY_EN
      default:  leds_nxt = hist;
`else
      default:  leds_nxt = run_cnt8;
`endif
    endcase
  end

  // Registered LED drive
  always_ff @(posedge clk) begin
    if (!reset) begin
      leds <= 8'd0;
    end else begin
      leds <= leds_nxt;
    end
  end

endmodule

// File: tb/tb_knn_result_display.sv
// tb/tb_knn_result_display.sv - directed self-checking bench for knn_result_display
module tb_knn_result_display;

  logic        clk;
  logic        reset;
  logic        done;
  logic        running;
  logic [1:0]  predicted_class;
  logic        K_mode;
  logic [15:0] latency;
  logic        btn_page;
  logic [7:0]  leds;
  logic        result_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  knn_result_display #(.BLINK_DIV(4), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .done            (done),
    .running         (running),
    .predicted_class (predicted_class),
    .K_mode          (K_mode),
    .latency         (latency),
    .btn_page        (btn_page),
    .leds            (leds),
    .result_valid    (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press();
    btn_page = 1'b1;
    tick();
    btn_page = 1'b0;
    tick();
  endtask

  task automatic capture(input logic [1:0] cls, input logic k, input logic [15:0] lat);
    predicted_class = cls;
    K_mode          = k;
    latency         = lat;
    done            = 1'b1;
    tick();
    done            = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] exp_runs;
    logic [7:0] exp_runs_after_reset;
    reset = 1'b0; done = 1'b0; running = 1'b0; predicted_class = 2'd0;
    K_mode = 1'b0; latency = 16'd0; btn_page = 1'b0;

    // reset state
    tick(); tick();
    check("reset_leds", 16'(leds), 16'h00);
    check("reset_valid", 16'(result_valid), 16'h0);
    reset = 1'b1;
    tick();

    // idle: every page dark, page wraps back to result after four presses
    check("idle_p0", 16'(leds), 16'h00);
    press(); check("idle_p1", 16'(leds), 16'h00);
    press(); check("idle_p2", 16'(leds), 16'h00);
    press(); check("idle_p3", 16'(leds), 16'h00);
    press(); check("idle_p0_again", 16'(leds), 16'h00);
    check("idle_page_wrap", 16'(dut.page), 16'h0);
    check("idle_valid", 16'(result_valid), 16'h0);

    // blink with BLINK_DIV=4: LED bit 7 toggles every 4 cycles
    running = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      tick();
      check($sformatf("blink_%0d", n), 16'(leds), 16'(((n - 1) / 4) % 2 ? 8'h80 : 8'h00));
    end
    running = 1'b0;
    tick();
    check("blink_off", 16'(leds), 16'h00);

    // done held 5 cycles; class changes mid-pulse must not leak into the capture
    predicted_class = 2'b10; K_mode = 1'b1; latency = 16'h1234; done = 1'b1;
    tick(); tick();
    predicted_class = 2'b01; latency = 16'hFFFF;
    tick(); tick(); tick();
    done = 1'b0;
    tick();
    check("cap1_p0", 16'(leds), 16'h1E);
    check("cap1_valid", 16'(result_valid), 16'h1);
    press(); check("cap1_lat_lo", 16'(leds), 16'h34);
    press(); check("cap1_lat_hi", 16'(leds), 16'h12);
`ifdef KNN_RESULT_HISTORY_EN
    exp_runs = 8'h02;
`else
    exp_runs = 8'h01;
`endif
    press(); check("cap1_runs", 16'(leds), 16'(exp_runs));
    press(); check("cap1_back_p0", 16'(leds), 16'h1E);

    // capture coincident with button on P_LAT_HI: capture wins, page returns to result
    press(); press();
    check("pre_force_lat_hi", 16'(leds), 16'h12);
    predicted_class = 2'b01; K_mode = 1'b0; latency = 16'hABCD;
    done = 1'b1; btn_page = 1'b1;
    tick();
    done = 1'b0; btn_page = 1'b0;
    tick();
    check("force_p0", 16'(leds), 16'h29);
    press(); check("force_next_lat_lo", 16'(leds), 16'hCD);
    press(); check("force_next_lat_hi", 16'(leds), 16'hAB);

    // 254 more captures bring the count to 256, wrapping to zero; last four classes 01,10,11,00
    for (int i = 0; i < 254; i++) begin
      logic [1:0] cls;
      case (i)
        250: cls = 2'b01;
        251: cls = 2'b10;
        252: cls = 2'b11;
        253: cls = 2'b00;
        default: cls = 2'(i);
      endcase
      capture(cls, 1'b1, 16'(i));
    end
    check("wrap_p0", 16'(leds), 16'h0C);
    check("wrap_valid", 16'(result_valid), 16'h1);
    press(); check("wrap_lat_lo", 16'(leds), 16'hFD);
    press(); check("wrap_lat_hi", 16'(leds), 16'h00);
`ifdef KNN_RESULT_HISTORY_EN
    exp_runs = 8'b0110_1100;
`else
    exp_runs = 8'h00;
`endif
    press(); check("wrap_runs", 16'(leds), 16'(exp_runs));

    // reset in the middle of a run and a capture clears everything
    running = 1'b1; predicted_class = 2'b11; K_mode = 1'b1; latency = 16'h5A5A;
    tick(); tick(); tick(); tick(); tick();
    done = 1'b1;
    reset = 1'b0;
    tick();
    check("midreset_leds", 16'(leds), 16'h00);
    check("midreset_valid", 16'(result_valid), 16'h0);
    running = 1'b0; done = 1'b0; reset = 1'b1;
    tick();
    check("post_reset_p0", 16'(leds), 16'h00);
    press(); check("post_reset_lat_lo", 16'(leds), 16'h00);
    press(); check("post_reset_lat_hi", 16'(leds), 16'h00);
    exp_runs_after_reset = 8'h00;
    press(); check("post_reset_runs", 16'(leds), 16'(exp_runs_after_reset));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
